// File: rtl/jtpopeye_objdraw.sv
// Object pixel serialiser: 2-deep descriptor queue, ROM row fetch over a cs/ok
// handshake, staging register and a PLANES x PW shifter with flip and palette.
module jtpopeye_objdraw #(
  parameter int unsigned PLANES = 2,
  parameter int unsigned PW     = 16,
  parameter int unsigned CW     = 3,
  parameter int unsigned AW     = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pxl_cen,
  input  logic                 blank,
  input  logic                 obj_we,
  input  logic [AW-1:0]        obj_addr,
  input  logic [CW-1:0]        obj_pal,
  input  logic                 obj_hflip,
  input  logic                 obj_en,
  output logic                 obj_full,
  output logic                 rom_cs,
  output logic [AW-1:0]        rom_addr,
  input  logic                 rom_ok,
  input  logic [PLANES*PW-1:0] rom_data,
  output logic [PLANES-1:0]    pxl_col,
  output logic [CW-1:0]        pxl_pal,
  output logic                 pxl_vld,
  output logic                 pxl_opaque
);

  localparam int unsigned CNTW = $clog2(PW + 1);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(PW);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t                   state_q, state_d;
  logic                     cs_q, cs_d;
  logic [AW-1:0]            addr_q, addr_d;

  logic [1:0]               qcnt_q, qcnt_d;
  logic                     full_q;
  logic [1:0][AW-1:0]       qa_q;
  logic [1:0][CW-1:0]       qp_q;
  logic [1:0]               qh_q, qe_q;
  logic                     push, pop, widx;

  logic                     stg_vld_q, stg_vld_d;
  logic [PLANES*PW-1:0]     stg_data_q;
  logic [CW-1:0]            stg_pal_q;
  logic                     stg_hflip_q;
  logic                     stg_wr, stg_zero, ld;

  logic [PLANES-1:0][PW-1:0] sh_q, sh_d;
  logic [CW-1:0]            cur_pal_q, cur_pal_d;
  logic                     cur_hflip_q, cur_hflip_d;
  logic [CNTW-1:0]          cnt_q, cnt_d;
  logic [PLANES-1:0]        col_q, col_d;
  logic [CW-1:0]            pal_q, pal_d;
  logic                     vld_q, vld_d;
  logic                     opq_q, opq_d;

  assign push = obj_we && !full_q && !blank;
  // With a pop the head slot shifts down, so the free slot index drops by one.
  assign widx = pop ? qcnt_q[1] : qcnt_q[0];
  assign ld   = pxl_cen && !blank && stg_vld_q && (cnt_q <= CNT_ONE);

  always_comb begin
    state_d  = state_q;
    cs_d     = cs_q;
    addr_d   = addr_q;
    pop      = 1'b0;
    stg_wr   = 1'b0;
    stg_zero = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cs_d = 1'b0;
        if (qcnt_q != 2'd0 && !stg_vld_q) begin
          if (qe_q[0]) begin
            cs_d    = 1'b1;
            addr_d  = qa_q[0];
            state_d = ST_WAIT;
          end else begin
            stg_wr   = 1'b1;
            stg_zero = 1'b1;
            pop      = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // cs stays high one more edge; IDLE then lowers it.
        if (rom_ok) begin
          stg_wr  = 1'b1;
          pop     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (blank) begin
      state_d = ST_IDLE;
      cs_d    = 1'b0;
      pop     = 1'b0;
      stg_wr  = 1'b0;
    end
  end

  always_comb begin
    case ({push, pop})
      2'b10:   qcnt_d = qcnt_q + 2'd1;
      2'b01:   qcnt_d = qcnt_q - 2'd1;
      default: qcnt_d = qcnt_q;
    endcase
    if (blank) qcnt_d = '0;

    if (blank)       stg_vld_d = 1'b0;
    else if (stg_wr) stg_vld_d = 1'b1;
    else if (ld)     stg_vld_d = 1'b0;
    else             stg_vld_d = stg_vld_q;
  end

  always_comb begin
    sh_d        = sh_q;
    cur_pal_d   = cur_pal_q;
    cur_hflip_d = cur_hflip_q;
    cnt_d       = cnt_q;
    col_d       = col_q;
    pal_d       = pal_q;
    vld_d       = vld_q;
    if (blank) begin
      cnt_d = '0;
      if (pxl_cen) begin
        col_d = '0;
        vld_d = 1'b0;
      end
    end else if (pxl_cen) begin
      if (cnt_q != '0) begin
        for (int unsigned p = 0; p < PLANES; p++) begin
          col_d[p] = cur_hflip_q ? sh_q[p][PW-1] : sh_q[p][0];
          sh_d[p]  = cur_hflip_q ? (sh_q[p] << 1) : (sh_q[p] >> 1);
        end
        pal_d = cur_pal_q;
        vld_d = 1'b1;
        cnt_d = cnt_q - CNT_ONE;
      end else begin
        col_d = '0;
        vld_d = 1'b0;
      end
      if (ld) begin
        for (int unsigned p = 0; p < PLANES; p++)
          sh_d[p] = stg_data_q[p*PW +: PW];
        cnt_d       = CNT_FULL;
        cur_pal_d   = stg_pal_q;
        cur_hflip_d = stg_hflip_q;
      end
    end
    opq_d = vld_d && (|col_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cs_q        <= 1'b0;
      addr_q      <= '0;
      qcnt_q      <= '0;
      full_q      <= 1'b0;
      qa_q        <= '0;
      qp_q        <= '0;
      qh_q        <= '0;
      qe_q        <= '0;
      stg_vld_q   <= 1'b0;
      stg_data_q  <= '0;
      stg_pal_q   <= '0;
      stg_hflip_q <= 1'b0;
      sh_q        <= '0;
      cur_pal_q   <= '0;
      cur_hflip_q <= 1'b0;
      cnt_q       <= '0;
      col_q       <= '0;
      pal_q       <= '0;
      vld_q       <= 1'b0;
      opq_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      addr_q  <= addr_d;
      qcnt_q  <= qcnt_d;
      full_q  <= (qcnt_d == 2'd2);
      if (pop) begin
        qa_q[0] <= qa_q[1];
        qp_q[0] <= qp_q[1];
        qh_q[0] <= qh_q[1];
        qe_q[0] <= qe_q[1];
      end
      if (push) begin
        qa_q[widx] <= obj_addr;
        qp_q[widx] <= obj_pal;
        qh_q[widx] <= obj_hflip;
        qe_q[widx] <= obj_en;
      end
      stg_vld_q <= stg_vld_d;
      if (stg_wr) begin
        stg_data_q  <= stg_zero ? '0 : rom_data;
        stg_pal_q   <= qp_q[0];
        stg_hflip_q <= qh_q[0];
      end
      sh_q        <= sh_d;
      cur_pal_q   <= cur_pal_d;
      cur_hflip_q <= cur_hflip_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      pal_q       <= pal_d;
      vld_q       <= vld_d;
      opq_q       <= opq_d;
    end
  end

  assign obj_full   = full_q;
  assign rom_cs     = cs_q;
  assign rom_addr   = addr_q;
  assign pxl_col    = col_q;
  assign pxl_pal    = pal_q;
  assign pxl_vld    = vld_q;
  assign pxl_opaque = opq_q;

endmodule
